// File: rtl/timer_csr_arb.sv
// Two-requester arbiter/sequencer for the timer CSR bram port (1-cycle read latency).
// Define TIMER_CSR_ARB_RR_EN for round-robin tie-breaking; default build is fixed priority (req0 wins).
module timer_csr_arb #(
   parameter int ADD_WIDTH = 8
) (
   input  logic                 aclk,
   input  logic                 aresetn,
   input  logic                 req0,
   input  logic                 we0,
   input  logic [ADD_WIDTH-1:0] addr0,
   input  logic [31:0]          wdata0,
   output logic                 ack0,
   output logic [31:0]          rdata0,
   input  logic                 req1,
   input  logic                 we1,
   input  logic [ADD_WIDTH-1:0] addr1,
   input  logic [31:0]          wdata1,
   output logic                 ack1,
   output logic [31:0]          rdata1,
   output logic [ADD_WIDTH-1:0] bram_addr,
   output logic                 bram_wr,
   output logic [31:0]          bram_wr_data,
   output logic                 bram_rd,
   input  logic [31:0]          bram_rd_data,
   output logic                 busy,
   output logic                 gnt_id
);
   typedef enum logic [1:0] {IDLE, ACC, CAP, RSP} state_t;

   state_t               r_state;
   logic                 r_we;
   logic                 r_gnt;
   logic                 r_ack0;
   logic                 r_ack1;
   logic                 r_wr;
   logic                 r_rd;
   logic                 r_busy;
   logic [ADD_WIDTH-1:0] r_addr;
   logic [31:0]          r_wdata;
   logic [31:0]          r_rdata0;
   logic [31:0]          r_rdata1;

   logic                 w_win;
   logic                 w_we;
   logic [ADD_WIDTH-1:0] w_addr;
   logic [31:0]          w_wdata;

`ifdef TIMER_CSR_ARB_RR_EN
   logic                 r_last_gnt;
   // On a tie the requester not served last goes first; a lone requester always wins.
   assign w_win = (req0 && req1) ? ~r_last_gnt : ~req0;
`else
   assign w_win = ~req0;
`endif

   assign w_we    = w_win ? we1    : we0;
   assign w_addr  = w_win ? addr1  : addr0;
   assign w_wdata = w_win ? wdata1 : wdata0;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state  <= IDLE;
         r_we     <= 1'b0;
         r_gnt    <= 1'b0;
         r_ack0   <= 1'b0;
         r_ack1   <= 1'b0;
         r_wr     <= 1'b0;
         r_rd     <= 1'b0;
         r_busy   <= 1'b0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_rdata0 <= '0;
         r_rdata1 <= '0;
`ifdef TIMER_CSR_ARB_RR_EN
         r_last_gnt <= 1'b1;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (req0 || req1) begin
                  r_gnt   <= w_win;
                  r_we    <= w_we;
                  r_addr  <= w_addr;
                  r_wdata <= w_wdata;
                  r_wr    <= w_we;
                  r_rd    <= ~w_we;
                  r_busy  <= 1'b1;
                  r_state <= ACC;
               end
            end
            ACC: begin
               r_wr <= 1'b0;
               r_rd <= 1'b0;
               if (r_we) begin
                  r_ack0  <= ~r_gnt;
                  r_ack1  <= r_gnt;
                  r_state <= RSP;
               end else begin
                  r_state <= CAP;
               end
            end
            CAP: begin
               // CSR read data is valid here, one cycle after the read strobe.
               if (r_gnt) r_rdata1 <= bram_rd_data;
               else       r_rdata0 <= bram_rd_data;
               r_ack0  <= ~r_gnt;
               r_ack1  <= r_gnt;
               r_state <= RSP;
            end
            RSP: begin
               r_ack0  <= 1'b0;
               r_ack1  <= 1'b0;
               r_busy  <= 1'b0;
`ifdef TIMER_CSR_ARB_RR_EN
               r_last_gnt <= r_gnt;
`endif
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign ack0         = r_ack0;
   assign ack1         = r_ack1;
   assign rdata0       = r_rdata0;
   assign rdata1       = r_rdata1;
   assign bram_addr    = r_addr;
   assign bram_wr      = r_wr;
   assign bram_wr_data = r_wdata;
   assign bram_rd      = r_rd;
   assign busy         = r_busy;
   assign gnt_id       = r_gnt;

`ifndef SYNTHESIS
   // A pending request (high, not yet acked) must keep we/addr/wdata stable.
   logic [1:0]           r_pend;
   logic [ADD_WIDTH+32:0] r_hold0;
   logic [ADD_WIDTH+32:0] r_hold1;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_pend  <= '0;
         r_hold0 <= '0;
         r_hold1 <= '0;
      end else begin
         if ((req0 && r_pend[0] && ({we0, addr0, wdata0} != r_hold0)) ||
             (req1 && r_pend[1] && ({we1, addr1, wdata1} != r_hold1)))
            $display("%t %m ERROR", $time);
         r_pend  <= {req1 & ~r_ack1, req0 & ~r_ack0};
         r_hold0 <= {we0, addr0, wdata0};
         r_hold1 <= {we1, addr1, wdata1};
      end
   end
`endif
endmodule

// File: tb/tb_timer_csr_arb.sv
// Bench for timer_csr_arb: directed scenarios plus random traffic against a transaction-level model.
module tb_timer_csr_arb;
   localparam int AW = 8;

   logic          aclk = 1'b0;
   logic          aresetn;
   logic          req0, we0, req1, we1;
   logic [AW-1:0] addr0, addr1;
   logic [31:0]   wdata0, wdata1;
   logic          ack0, ack1;
   logic [31:0]   rdata0, rdata1;
   logic [AW-1:0] bram_addr;
   logic          bram_wr, bram_rd;
   logic [31:0]   bram_wr_data;
   logic [31:0]   bram_rd_data;
   logic          busy, gnt_id;

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // Transaction-level reference: CSR contents, per-requester read data, last served id.
   logic [31:0] ref_mem [logic [AW-1:0]];
   logic [31:0] ref_rdata [2];
   bit          ref_last;

   // CSR memory model behind the bram port.
   logic [31:0] csr_mem [logic [AW-1:0]];

   timer_csr_arb #(.ADD_WIDTH(AW)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
      .bram_addr(bram_addr), .bram_wr(bram_wr), .bram_wr_data(bram_wr_data),
      .bram_rd(bram_rd), .bram_rd_data(bram_rd_data), .busy(busy), .gnt_id(gnt_id)
   );

   always #5 aclk = ~aclk;

   // Unwritten CSR locations read back a fixed pattern; 0x0C returns 0x12345678.
   function automatic logic [31:0] dflt(input logic [AW-1:0] a);
      return 32'h12345678 ^ {24'h0, a ^ 8'h0C};
   endfunction

   always @(posedge aclk) begin
      if (bram_wr) csr_mem[bram_addr] = bram_wr_data;
      if (bram_rd) bram_rd_data <= csr_mem.exists(bram_addr) ? csr_mem[bram_addr] : dflt(bram_addr);
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
      cyc++;
      chk("strobe_exclusive", 32'(bram_wr & bram_rd), 32'd0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ack0"},  32'(ack0), 32'd0);
      chk({tag, "_ack1"},  32'(ack1), 32'd0);
      chk({tag, "_rdata0"}, rdata0, 32'd0);
      chk({tag, "_rdata1"}, rdata1, 32'd0);
      chk({tag, "_addr"},  32'(bram_addr), 32'd0);
      chk({tag, "_wr"},    32'(bram_wr), 32'd0);
      chk({tag, "_wdata"}, bram_wr_data, 32'd0);
      chk({tag, "_rd"},    32'(bram_rd), 32'd0);
      chk({tag, "_busy"},  32'(busy), 32'd0);
      chk({tag, "_gnt"},   32'(gnt_id), 32'd0);
   endtask

   // Arbitration rule: lone requester wins; ties go to req0, or to the one not served last under RR.
   function automatic bit pick(input bit r0, input bit r1);
`ifdef TIMER_CSR_ARB_RR_EN
      if (r0 && r1) return !ref_last;
`endif
      return r0 ? 1'b0 : 1'b1;
   endfunction

   // Called in an IDLE cycle with the request already driven; returns in the IDLE cycle after RSP.
   task automatic expect_txn(input string tag, input bit id, input bit we,
                             input logic [AW-1:0] a, input logic [31:0] d, output int scyc);
      int n;
      bit got;
      logic [31:0] exp_rd;
      exp_rd = ref_mem.exists(a) ? ref_mem[a] : dflt(a);
      n = 0; got = 0; scyc = -1;
      while (!got && n < 8) begin
         tick();
         n++;
         chk({tag, "_busy"}, 32'(busy), 32'd1);
         if (bram_wr || bram_rd) begin
            scyc = cyc;
            chk({tag, "_strobe_cycle"}, n, 32'd1);
            chk({tag, "_strobe_kind"}, 32'(bram_wr), 32'(we));
            chk({tag, "_addr"}, 32'(bram_addr), 32'(a));
            if (we) chk({tag, "_wdata"}, bram_wr_data, d);
            chk({tag, "_gnt"}, 32'(gnt_id), 32'(id));
         end
         if (ack0 || ack1) got = 1;
      end
      chk({tag, "_ack_seen"}, 32'(got), 32'd1);
      chk({tag, "_latency"}, n, we ? 32'd2 : 32'd3);
      chk({tag, "_ack0"}, 32'(ack0), 32'(id == 1'b0));
      chk({tag, "_ack1"}, 32'(ack1), 32'(id == 1'b1));
      if (we) ref_mem[a] = d;
      else    ref_rdata[id] = exp_rd;
      chk({tag, "_rdata0"}, rdata0, ref_rdata[0]);
      chk({tag, "_rdata1"}, rdata1, ref_rdata[1]);
      ref_last = id;
      tick();
      chk({tag, "_ack_one_cycle"}, 32'(ack0 | ack1), 32'd0);
      chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
      chk({tag, "_gnt_hold"}, 32'(gnt_id), 32'(ref_last));
   endtask

   initial begin
      int s, prev;
      bit w;
      aresetn = 1'b0;
      req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
      req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
      ref_rdata[0] = '0; ref_rdata[1] = '0; ref_last = 1'b1;
      #12;
      chk_all_zero("reset");
      aresetn = 1'b1;
      tick(); tick();
      chk("idle_busy", 32'(busy), 32'd0);

      // Single write from requester 0
      req0 = 1; we0 = 1; addr0 = 8'h08; wdata0 = 32'hDEADBEEF;
      expect_txn("wr0", 1'b0, 1'b1, 8'h08, 32'hDEADBEEF, s);
      req0 = 0;

      // Single read from requester 1
      req1 = 1; we1 = 0; addr1 = 8'h0C;
      expect_txn("rd1", 1'b1, 1'b0, 8'h0C, 32'h0, s);
      chk("rd1_value", rdata1, 32'h12345678);
      req1 = 0;

      // Tie, both reads, held back-to-back
      req0 = 1; we0 = 0; addr0 = 8'h10;
      req1 = 1; we1 = 0; addr1 = 8'h14;
      for (int k = 0; k < 4; k++) begin
         w = pick(1'b1, 1'b1);
         expect_txn("tie", w, 1'b0, w ? 8'h14 : 8'h10, 32'h0, s);
      end
      req0 = 0;
      expect_txn("tie_tail", 1'b1, 1'b0, 8'h14, 32'h0, s);
      req1 = 0;

      // Requester 1 arrives while a requester-0 write is in ACC
      req0 = 1; we0 = 1; addr0 = 8'h20; wdata0 = 32'hA5A50001;
      tick();
      chk("busy_wr_strobe", 32'(bram_wr), 32'd1);
      chk("busy_wr_addr", 32'(bram_addr), 32'h20);
      req1 = 1; we1 = 0; addr1 = 8'h20;
      tick();
      chk("busy_ack0", 32'(ack0), 32'd1);
      chk("busy_ack1", 32'(ack1), 32'd0);
      chk("busy_no_strobe", 32'(bram_wr | bram_rd), 32'd0);
      ref_mem[8'h20] = 32'hA5A50001;
      ref_last = 1'b0;
      tick();
      chk("busy_ack0_drop", 32'(ack0), 32'd0);
      req0 = 0;
      expect_txn("busy_rd1", 1'b1, 1'b0, 8'h20, 32'h0, s);
      chk("busy_rd1_value", rdata1, 32'hA5A50001);
      req1 = 0;

      // Reset while a read sits in CAP
      req1 = 1; we1 = 0; addr1 = 8'h30;
      tick(); tick();
      chk("cap_busy", 32'(busy), 32'd1);
      #2 aresetn = 1'b0;
      #1;
      chk_all_zero("mid_reset");
      req1 = 0;
      #3 aresetn = 1'b1;
      ref_rdata[0] = '0; ref_rdata[1] = '0; ref_last = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("post_reset_no_ack", 32'(ack0 | ack1), 32'd0);
      end
      req1 = 1; we1 = 0; addr1 = 8'h04;
      expect_txn("post_reset_rd", 1'b1, 1'b0, 8'h04, 32'h0, s);
      req1 = 0;

      // Back-to-back writes from requester 0
      req0 = 1; we0 = 1;
      prev = 0;
      for (int k = 0; k < 3; k++) begin
         addr0 = 8'(k * 4);
         wdata0 = $urandom;
         expect_txn("b2b", 1'b0, 1'b1, addr0, wdata0, s);
         if (k > 0) chk("b2b_spacing", s - prev, 32'd3);
         prev = s;
      end
      req0 = 0;

      // Random traffic
      for (int it = 0; it < 24; it++) begin
         bit r0, r1;
         int mode;
         mode = $urandom_range(0, 2);
         r0 = (mode != 1);
         r1 = (mode != 0);
         we0 = 1'($urandom_range(0, 1)); addr0 = 8'($urandom_range(0, 7) * 4); wdata0 = $urandom;
         we1 = 1'($urandom_range(0, 1)); addr1 = 8'($urandom_range(0, 7) * 4); wdata1 = $urandom;
         req0 = r0; req1 = r1;
         w = pick(r0, r1);
         expect_txn("rnd", w, w ? we1 : we0, w ? addr1 : addr0, w ? wdata1 : wdata0, s);
         if (w) req1 = 0; else req0 = 0;
         if (r0 && r1) begin
            expect_txn("rnd_loser", !w, w ? we0 : we1, w ? addr0 : addr1, w ? wdata0 : wdata1, s);
            req0 = 0; req1 = 0;
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
